dptr_rtype: RTL and testbench



---
 rtl/dptr_pkg.sv | 26 ++
 rtl/dptr_alu.sv | 30 +++
 rtl/dptr_rtype.sv | 75 +++++++
 tb/tb_dptr_rtype.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/dptr_pkg.sv
// Shared constants and types for the R-type datapath.
package dptr_pkg;

    localparam int DW_DEFAULT = 32;

    localparam logic [5:0] OP_RTYPE = 6'b000000;

    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_NOR = 6'b100111;
    localparam logic [5:0] F_SLT = 6'b101010;

    // ALU_NONE marks an invalid instruction: result forced to zero.
    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_NOR,
        ALU_SLT,
        ALU_NONE
    } alu_op_t;

endpackage

// File: rtl/dptr_alu.sv
// Combinational ALU for the R-type datapath; zero flag derived from result.
module dptr_alu
    import dptr_pkg::*;
#(
    parameter int DATA_W = DW_DEFAULT
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  alu_op_t           alu_op,
    output logic [DATA_W-1:0] result,
    output logic              zero
);

    // Operation select; add/sub wrap silently, SLT compares signed.
    always_comb begin
        result = '0;
        case (alu_op)
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_NOR: result = ~(a | b);
            ALU_SLT: result = ($signed(a) < $signed(b)) ? DATA_W'(1) : '0;
            default: result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/dptr_rtype.sv
// Single-cycle R-type datapath: decode, 32-entry register file, ALU, write-back.
module dptr_rtype
    import dptr_pkg::*;
#(
    parameter int DATA_W = DW_DEFAULT,
    parameter int NREGS  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       instruccion,
    output logic              zf,
    output logic [DATA_W-1:0] alu_result
);

    logic [5:0] opcode;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic [5:0] funct;
    logic       unused_shamt;

    assign opcode       = instruccion[31:26];
    assign rs           = instruccion[25:21];
    assign rt           = instruccion[20:16];
    assign rd           = instruccion[15:11];
    assign funct        = instruccion[5:0];
    assign unused_shamt = ^instruccion[10:6];

    alu_op_t           alu_op;
    logic              valid;
    logic [DATA_W-1:0] regs [NREGS];
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;

    // Funct decode; anything outside the supported set is treated as invalid.
    always_comb begin
        valid  = 1'b0;
        alu_op = ALU_NONE;
        if (opcode == OP_RTYPE) begin
            valid = 1'b1;
            case (funct)
                F_ADD:   alu_op = ALU_ADD;
                F_SUB:   alu_op = ALU_SUB;
                F_AND:   alu_op = ALU_AND;
                F_OR:    alu_op = ALU_OR;
                F_NOR:   alu_op = ALU_NOR;
                F_SLT:   alu_op = ALU_SLT;
                default: valid  = 1'b0;
            endcase
        end
    end

    // Asynchronous reads; register 0 is hardwired to zero regardless of storage.
    assign op_a = (rs == 5'd0) ? '0 : regs[rs];
    assign op_b = (rt == 5'd0) ? '0 : regs[rt];

    dptr_alu #(.DATA_W(DATA_W)) u_alu (
        .a      (op_a),
        .b      (op_b),
        .alu_op (alu_op),
        .result (alu_result),
        .zero   (zf)
    );

    // Reset loads reg[i] = i; write-back on the edge for valid ops to rd != 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++)
                regs[i] <= DATA_W'(i);
        end else if (valid && rd != 5'd0) begin
            regs[rd] <= alu_result;
        end
    end

endmodule

// File: tb/tb_dptr_rtype.sv
// Directed bench for dptr_rtype with a reference register model and a result scoreboard.
module tb_dptr_rtype;

    logic        clk;
    logic        reset;
    logic [31:0] instruccion;
    logic        zf;
    logic [31:0] alu_result;

    dptr_rtype dut (
        .clk         (clk),
        .reset       (reset),
        .instruccion (instruccion),
        .zf          (zf),
        .alu_result  (alu_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic        z;
        string       tag;
    } exp_t;

    exp_t        sb [$];
    logic [31:0] mregs [32];
    int          checks = 0;
    int          errors = 0;

    function automatic void model_reset();
        for (int i = 0; i < 32; i++) mregs[i] = 32'(i);
    endfunction

    function automatic logic model_valid(input logic [31:0] ins);
        logic [5:0] f;
        f = ins[5:0];
        return (ins[31:26] == 6'd0) &&
               (f == 6'h20 || f == 6'h22 || f == 6'h24 ||
                f == 6'h25 || f == 6'h27 || f == 6'h2A);
    endfunction

    function automatic logic [31:0] model_res(input logic [31:0] ins);
        logic [31:0] a, b;
        a = (ins[25:21] == 5'd0) ? 32'd0 : mregs[ins[25:21]];
        b = (ins[20:16] == 5'd0) ? 32'd0 : mregs[ins[20:16]];
        if (!model_valid(ins)) return 32'd0;
        case (ins[5:0])
            6'h20:   return a + b;
            6'h22:   return a - b;
            6'h24:   return a & b;
            6'h25:   return a | b;
            6'h27:   return ~(a | b);
            6'h2A:   return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    function automatic void push_exp(input logic [31:0] ins, input string tag);
        exp_t e;
        e.res = model_res(ins);
        e.z   = (e.res == 32'd0);
        e.tag = tag;
        sb.push_back(e);
    endfunction

    task automatic pop_check();
        exp_t e;
        checks++;
        assert (sb.size() != 0) else begin
            errors++;
            $error("FAIL scoreboard_empty got 0 entries exp 1");
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            checks++;
            assert (alu_result === e.res) else begin
                errors++;
                $error("FAIL %s result got %08h exp %08h", e.tag, alu_result, e.res);
            end
            checks++;
            assert (zf === e.z) else begin
                errors++;
                $error("FAIL %s zf got %0b exp %0b", e.tag, zf, e.z);
            end
        end
    endtask

    task automatic plan_check(input string tag, input logic [31:0] exp_res, input logic exp_z);
        checks++;
        assert (alu_result === exp_res) else begin
            errors++;
            $error("FAIL %s plan_result got %08h exp %08h", tag, alu_result, exp_res);
        end
        checks++;
        assert (zf === exp_z) else begin
            errors++;
            $error("FAIL %s plan_zf got %0b exp %0b", tag, zf, exp_z);
        end
    endtask

    // Drive on negedge, check mid-low-phase, let the rising edge commit, update model.
    task automatic exec(input logic [31:0] ins, input string tag,
                        input logic use_plan, input logic [31:0] plan_res);
        @(negedge clk);
        instruccion = ins;
        push_exp(ins, tag);
        #2;
        pop_check();
        if (use_plan) plan_check(tag, plan_res, plan_res == 32'd0);
        @(posedge clk);
        #1;
        if (model_valid(ins) && ins[15:11] != 5'd0)
            mregs[ins[15:11]] = model_res(ins);
    endtask

    initial begin
        reset       = 1'b1;
        instruccion = 32'h0000_0000;
        model_reset();
        #3;
        push_exp(instruccion, "reset_out");
        pop_check();
        plan_check("reset_out", 32'd0, 1'b1);
        @(negedge clk);
        reset = 1'b0;

        exec(32'h01E9A022, "sub_20_15_9",  1'b1, 32'd6);
        exec(32'h0289A022, "sub_20_20_9",  1'b1, 32'hFFFF_FFFD);
        exec(32'h00AF7820, "add_15_5_15",  1'b1, 32'd20);
        exec(32'h012F7820, "add_15_9_15",  1'b1, 32'd29);
        exec(32'h028FA82A, "slt_21_20_15", 1'b1, 32'd1);
        exec(32'h02A00020, "rd_reg21",     1'b1, 32'd1);
        exec(32'h01F4A82A, "slt_swapped",  1'b1, 32'd0);
        exec(32'h00E70822, "sub_1_7_7",    1'b1, 32'd0);
        exec(32'h00200020, "rd_reg1",      1'b1, 32'd0);
        exec(32'h00A35024, "and_5_3",      1'b1, 32'd1);
        exec(32'h00A35825, "or_5_3",       1'b1, 32'd7);
        exec(32'h00A36027, "nor_5_3",      1'b1, 32'hFFFF_FFF8);
        exec(32'h01800020, "rd_reg12",     1'b1, 32'hFFFF_FFF8);

        // Hold a read of $20 and pulse reset between edges.
        exec(32'h02800020, "rd_reg20_pre", 1'b1, 32'hFFFF_FFFD);
        #1;
        reset = 1'b1;
        model_reset();
        #1;
        push_exp(instruccion, "async_reset");
        pop_check();
        plan_check("async_reset", 32'd20, 1'b0);
        reset = 1'b0;

        exec(32'h01E9A022, "sub_again",    1'b1, 32'd6);
        exec(32'h00220020, "add_0_1_2",    1'b1, 32'd3);
        exec(32'h00001820, "add_3_0_0",    1'b1, 32'd0);
        exec(32'h08222820, "bad_opcode",   1'b1, 32'd0);
        exec(32'h00A00020, "rd_reg5_op",   1'b1, 32'd5);
        exec(32'h00222821, "bad_funct",    1'b1, 32'd0);
        exec(32'h00A00020, "rd_reg5_fn",   1'b1, 32'd5);

        // Pseudo-random valid and invalid ops against the model.
        for (int k = 0; k < 40; k++) begin
            logic [31:0] ins;
            logic [5:0]  fsel [7];
            fsel = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A, 6'h21};
            ins = {($urandom_range(0, 9) == 0) ? 6'h23 : 6'h00,
                   5'($urandom), 5'($urandom), 5'($urandom), 5'd0,
                   fsel[$urandom_range(0, 6)]};
            exec(ins, "rand", 1'b0, 32'd0);
        end

        checks++;
        assert (sb.size() == 0) else begin
            errors++;
            $error("FAIL scoreboard_leftover got %0d exp 0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout got running exp finished");
        $fatal(1, "timeout");
    end

endmodule
